pop_sorter: RTL and testbench

- Sorts one generation of a genetic-algorithm population by fitness and keeps the fittest half.
- Input is a packed bus of N individuals. Output is the OUT_N best individuals, ordered best first.
- Sits between the fitness-evaluation stage and the selection/crossover stage. It is a multi-cycle engine started by a one-cycle `start` pulse and reports completion with `done`.

---
 rtl/pop_sorter.sv | 135 +++++++++++++
 tb/tb_pop_sorter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pop_sorter.sv
// pop_sorter: multi-cycle population sorter for a genetic-algorithm pipeline.
// Loads N individuals on a start pulse, runs N odd-even transposition passes
// (one per clock) ordering by the top KEY_W bits, then publishes the OUT_N
// fittest individuals, best first, and raises done.
// Ties keep their input order because equal keys never swap.
module pop_sorter #(
    parameter int N     = 20,
    parameter int W     = 30,
    parameter int KEY_W = 10,
    parameter int OUT_N = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*W-1:0]     in,
    output logic [OUT_N*W-1:0] sorted,
    output logic               done
);

    // Pass counter width: it has to hold the values 0..N.
    localparam int CNT_W = 5;

    // The counter value at which every pass has been applied and the
    // result may be published.
    localparam logic [CNT_W-1:0] PASS_END = CNT_W'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   pass_q;
    logic               done_q;
    logic [OUT_N*W-1:0] sorted_q;
    logic [W-1:0]       a_q [N];
    logic [W-1:0]       a_d [N];

    // Fitness key: the most significant KEY_W bits of an individual.
    function automatic logic [KEY_W-1:0] key_of(input logic [W-1:0] word);
        return word[W-1 -: KEY_W];
    endfunction

    // True when the upper element of a pair is strictly fitter than the
    // lower one; equal keys leave the pair untouched so the sort is stable.
    function automatic logic ranks_above(input logic [W-1:0] upper_w,
                                         input logic [W-1:0] lower_w);
        return (key_of(upper_w) > key_of(lower_w));
    endfunction

    // Compare-swap network: even counter pairs (0,1),(2,3)..., odd counter
    // pairs (1,2),(3,4)...; unpaired end elements pass straight through.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_d[k] = a_q[k];
        end
        if (pass_q[0] == 1'b0) begin
            for (int k = 0; k < N - 1; k += 2) begin
                if (ranks_above(a_q[k+1], a_q[k])) begin
                    a_d[k]   = a_q[k+1];
                    a_d[k+1] = a_q[k];
                end else begin
                    a_d[k]   = a_q[k];
                    a_d[k+1] = a_q[k+1];
                end
            end
        end else begin
            for (int k = 1; k < N - 1; k += 2) begin
                if (ranks_above(a_q[k+1], a_q[k])) begin
                    a_d[k]   = a_q[k+1];
                    a_d[k+1] = a_q[k];
                end else begin
                    a_d[k]   = a_q[k];
                    a_d[k+1] = a_q[k+1];
                end
            end
        end
    end

    // Control FSM with registered outputs: load on start, one pass per
    // clock, publish the top OUT_N once all N passes are applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pass_q   <= '0;
            done_q   <= 1'b0;
            sorted_q <= '0;
            for (int k = 0; k < N; k++) begin
                a_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Fresh generation: done drops now, sorted keeps the
                        // previous result until the new one is ready.
                        for (int k = 0; k < N; k++) begin
                            a_q[k] <= in[k*W +: W];
                        end
                        pass_q  <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_SORT;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_SORT: begin
                    if (pass_q == PASS_END) begin
                        for (int j = 0; j < OUT_N; j++) begin
                            sorted_q[j*W +: W] <= a_q[j];
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        // start is deliberately ignored while sorting.
                        for (int k = 0; k < N; k++) begin
                            a_q[k] <= a_d[k];
                        end
                        pass_q <= pass_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pass_q  <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sorted = sorted_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pop_sorter.sv
// Testbench for pop_sorter: a cycle-level reference model (stable selection
// of the fittest OUT_N, published N+1 edges after the load edge) checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_pop_sorter;

    localparam int N     = 20;
    localparam int W     = 30;
    localparam int KEY_W = 10;
    localparam int OUT_N = 10;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [N*W-1:0]     in_v;
    logic [OUT_N*W-1:0] sorted;
    logic               done;

    int n_tests;
    int n_fail;

    pop_sorter #(.N(N), .W(W), .KEY_W(KEY_W), .OUT_N(OUT_N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in     (in_v),
        .sorted (sorted),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mk(input int key, input int pay);
        logic [W-1:0] w;
        w = {key[KEY_W-1:0], pay[W-KEY_W-1:0]};
        return w;
    endfunction

    // Repeatedly pick the fittest unused individual; strict '>' means the
    // lowest input index wins a tie.
    function automatic logic [OUT_N*W-1:0] model_sort(input logic [N*W-1:0] v);
        logic [OUT_N*W-1:0] r;
        bit used [N];
        int best;
        r = '0;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int j = 0; j < OUT_N; j++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (v[i*W+W-1 -: KEY_W] > v[best*W+W-1 -: KEY_W]) best = i;
                end
            end
            used[best] = 1'b1;
            r[j*W +: W] = v[best*W +: W];
        end
        return r;
    endfunction

    bit                 m_valid = 1'b0;
    bit                 m_busy  = 1'b0;
    int                 m_cnt   = 0;
    logic               m_done  = 1'b0;
    logic [OUT_N*W-1:0] m_sorted  = '0;
    logic [OUT_N*W-1:0] m_pending = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_cnt    = 0;
            m_done   = 1'b0;
            m_sorted = '0;
        end else if (m_valid) begin
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_sorted = m_pending;
                end
            end else if (start) begin
                m_pending = model_sort(in_v);
                m_busy    = 1'b1;
                m_cnt     = N + 1;
                m_done    = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [OUT_N*W-1:0] got,
                         input logic [OUT_N*W-1:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_done", {{(OUT_N*W-1){1'b0}}, done}, {{(OUT_N*W-1){1'b0}}, m_done});
            check("model_sorted", sorted, m_sorted);
        end
    end

    // Pulse start with v; report done/sorted right after the load edge and
    // the number of edges from the load edge until done is seen (-1: timeout).
    task automatic run_sort(input logic [N*W-1:0] v, output int lat,
                            output logic d0, output logic [OUT_N*W-1:0] s0);
        in_v  = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done;
        s0 = sorted;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    logic signed [31:0] s32;
    logic [N*W-1:0]     v_desc, v_eq, v_rand, v_ones;
    logic [OUT_N*W-1:0] exp_desc, exp_eq, s0;
    logic               d0;
    int                 lat;
    int                 k_mid;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b1;
        in_v    = '1;

        // Stimulus tables.
        s32    = -32'sd135945636;
        v_ones = {{(N*W-32){s32[31]}}, s32};
        v_desc = '0; v_eq = '0; v_rand = '0;
        exp_desc = '0; exp_eq = '0;
        for (int i = 0; i < N; i++) begin
            v_desc[i*W +: W] = mk(i, i);
            v_eq[i*W +: W]   = mk(500, i);
            v_rand[i*W +: W] = mk($urandom_range(0, 7), $urandom);
        end
        for (int j = 0; j < OUT_N; j++) begin
            exp_desc[j*W +: W] = mk(19 - j, 19 - j);
            exp_eq[j*W +: W]   = mk(500, j);
        end

        // Reset held with start high: nothing may start.
        repeat (3) @(negedge clk);
        check("reset_done", {{(OUT_N*W-1){1'b0}}, done}, '0);
        check("reset_sorted", sorted, '0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_start", {{(OUT_N*W-1){1'b0}}, done}, '0);

        // Sign-extended all-ones population.
        check("word0_pin", {{(OUT_N*W-W){1'b0}}, v_ones[W-1:0]}, {{(OUT_N*W-32){1'b0}}, 32'h37E5A25C});
        run_sort(v_ones, lat, d0, s0);
        check("ones_latency", OUT_N*W'(lat), OUT_N*W'(21));
        check("ones_sorted", sorted, {(OUT_N*W){1'b1}});

        // Ascending keys in, descending out.
        run_sort(v_desc, lat, d0, s0);
        check("desc_latency", OUT_N*W'(lat), OUT_N*W'(21));
        check("desc_sorted", sorted, exp_desc);

        // All keys equal: input order preserved.
        run_sort(v_eq, lat, d0, s0);
        check("stable_sorted", sorted, exp_eq);

        // Back-to-back from DONE: done drops at once, old result held.
        run_sort(v_rand, lat, d0, s0);
        check("b2b_done_drop", {{(OUT_N*W-1){1'b0}}, d0}, '0);
        check("b2b_hold_old", s0, exp_eq);
        check("b2b_latency", OUT_N*W'(lat), OUT_N*W'(21));
        check("b2b_sorted_model", sorted, model_sort(v_rand));

        // Start pulse and new input mid-sort are ignored.
        in_v  = v_desc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k_mid = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 5) begin
                in_v  = v_ones;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                k_mid = k;
                break;
            end
        end
        start = 1'b0;
        check("midstart_latency", OUT_N*W'(k_mid), OUT_N*W'(21));
        check("midstart_sorted", sorted, exp_desc);

        // Reset mid-sort discards everything.
        in_v  = v_rand;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_done", {{(OUT_N*W-1){1'b0}}, done}, '0);
        check("midrst_sorted", sorted, '0);
        repeat (30) @(negedge clk);
        check("midrst_no_done", {{(OUT_N*W-1){1'b0}}, done}, '0);

        // start held high: repeated sorts, checked cycle by cycle by the model.
        in_v  = v_desc;
        start = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("held_start_sorted", sorted, exp_desc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
